// File: rtl/game_pkg.sv
// game_pkg: shared screen and sprite geometry, fixed-point format and smiley motion types.
package game_pkg;
    localparam int SCREEN_WIDTH      = 640;
    localparam int SCREEN_HEIGHT     = 480;
    localparam int SMILEY_WIDTH      = 64;
    localparam int SMILEY_HEIGHT     = 32;
    localparam int FIXED_POINT_SHIFT = 6;

    typedef enum logic [1:0] {
        EDGE_BOTTOM = 2'd0,
        EDGE_RIGHT  = 2'd1,
        EDGE_TOP    = 2'd2,
        EDGE_LEFT   = 2'd3
    } edge_code_t;

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_UPDATE, S_POSITION} move_state_t;

    function automatic logic signed [17:0] clamp_fp(input logic signed [17:0] v, input logic signed [17:0] hi);
        return v[17] ? '0 : (v > hi ? hi : v);
    endfunction
endpackage

// File: rtl/hit_edge_latch.sv
// hit_edge_latch: four sticky edge-hit flags; a set in the clearing cycle survives the clear.
module hit_edge_latch (
    input  logic       clk,
    input  logic       resetN,
    input  logic       set_i,
    input  logic       clr_i,
    input  logic [3:0] code_i,
    output logic [3:0] flags_o
);
    logic [3:0] flags_q, flags_d;

    assign flags_d = (clr_i ? 4'b0 : flags_q) | (set_i ? code_i : 4'b0);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) flags_q <= '0;
        else         flags_q <= flags_d;
    end

    assign flags_o = flags_q;
endmodule

// File: rtl/smiley_move_ctrl.sv
// smiley_move_ctrl: per-frame velocity, gravity and edge-bounce update of the smiley top-left corner.
module smiley_move_ctrl
    import game_pkg::*;
#(
    parameter int INITIAL_X       = 280,
    parameter int INITIAL_Y       = 185,
    parameter int INITIAL_X_SPEED = 40,
    parameter int INITIAL_Y_SPEED = 20,
    parameter int Y_ACCEL         = 1,
    parameter int MAX_Y_SPEED     = 230
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        launch,
    input  logic        park,
    input  logic        collision,
    input  logic [3:0]  HitEdgeCode,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        moving
);
    localparam logic signed [17:0] PARK_X    = 18'(INITIAL_X << FIXED_POINT_SHIFT);
    localparam logic signed [17:0] PARK_Y    = 18'(INITIAL_Y << FIXED_POINT_SHIFT);
    localparam logic signed [17:0] MAX_X     = 18'((SCREEN_WIDTH - SMILEY_WIDTH) << FIXED_POINT_SHIFT);
    localparam logic signed [17:0] MAX_Y     = 18'((SCREEN_HEIGHT - SMILEY_HEIGHT) << FIXED_POINT_SHIFT);
    localparam logic signed [17:0] LAUNCH_XS = 18'(INITIAL_X_SPEED);
    localparam logic signed [17:0] LAUNCH_YS = 18'(INITIAL_Y_SPEED);
    localparam logic signed [17:0] ACCEL     = 18'(Y_ACCEL);
    localparam logic signed [17:0] MAX_YS    = 18'(MAX_Y_SPEED);

    move_state_t        state_q, state_d;
    logic signed [17:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic signed [17:0] spd_x_q, spd_x_d, spd_y_q, spd_y_d;
    logic signed [17:0] bnc_x, bnc_y;
    logic [10:0]        out_x_q, out_y_q;
    logic [3:0]         hit;

    // A parking update drops any hit seen in that cycle so the flags come back clean.
    hit_edge_latch u_hit (
        .clk     (clk),
        .resetN  (resetN),
        .set_i   (collision && (state_q == S_MOVE || (state_q == S_UPDATE && !park))),
        .clr_i   (state_q == S_UPDATE),
        .code_i  (HitEdgeCode),
        .flags_o (hit)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_IDLE;
            pos_x_q <= PARK_X;
            pos_y_q <= PARK_Y;
            spd_x_q <= '0;
            spd_y_q <= '0;
            out_x_q <= PARK_X[FIXED_POINT_SHIFT +: 11];
            out_y_q <= PARK_Y[FIXED_POINT_SHIFT +: 11];
        end else begin
            state_q <= state_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            spd_x_q <= spd_x_d;
            spd_y_q <= spd_y_d;
            out_x_q <= pos_x_q[FIXED_POINT_SHIFT +: 11];
            out_y_q <= pos_y_q[FIXED_POINT_SHIFT +: 11];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     state_d = launch ? S_MOVE : S_IDLE;
            S_MOVE:     state_d = startOfFrame ? S_UPDATE : S_MOVE;
            S_UPDATE:   state_d = park ? S_IDLE : S_POSITION;
            S_POSITION: state_d = S_MOVE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Only reverse a speed that is heading into the wall that was hit.
    assign bnc_x = ((hit[EDGE_LEFT] && spd_x_q[17]) || (hit[EDGE_RIGHT] && !spd_x_q[17] && spd_x_q != 18'sd0)) ? -spd_x_q : spd_x_q;
    assign bnc_y = ((hit[EDGE_TOP] && spd_y_q[17]) || (hit[EDGE_BOTTOM] && !spd_y_q[17] && spd_y_q != 18'sd0)) ? -spd_y_q : spd_y_q;

    always_comb begin
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        spd_x_d = spd_x_q;
        spd_y_d = spd_y_q;
        case (state_q)
            S_IDLE: begin
                pos_x_d = PARK_X;
                pos_y_d = PARK_Y;
                spd_x_d = launch ? LAUNCH_XS : spd_x_q;
                spd_y_d = launch ? LAUNCH_YS : spd_y_q;
            end
            S_UPDATE: begin
                pos_x_d = park ? PARK_X : pos_x_q;
                pos_y_d = park ? PARK_Y : pos_y_q;
                spd_x_d = park ? '0 : bnc_x;
                spd_y_d = park ? '0 : (bnc_y < MAX_YS ? bnc_y + ACCEL : bnc_y);
            end
            S_POSITION: begin
                pos_x_d = clamp_fp(pos_x_q + spd_x_q, MAX_X);
                pos_y_d = clamp_fp(pos_y_q + spd_y_q, MAX_Y);
            end
            default: ;
        endcase
    end

    assign topLeftX = out_x_q;
    assign topLeftY = out_y_q;
    assign moving   = state_q != S_IDLE;
endmodule

// File: tb/tb_smiley_move_ctrl.sv
// tb_smiley_move_ctrl: directed checks of park, launch, bounce, gravity saturation, clamping, park and async reset.
module tb_smiley_move_ctrl;
    import game_pkg::*;

    logic        clk = 1'b0, resetN = 1'b0, sof = 1'b0, launch = 1'b0, launch_b = 1'b0, park = 1'b0, collision = 1'b0;
    logic [3:0]  code = 4'b0;
    logic [10:0] ax, ay, bx, by;
    logic        am, bm;
    int          checks = 0, passes = 0;
    int          px, py, sx, sy;

    always #5 clk = ~clk;

    smiley_move_ctrl #(.INITIAL_X_SPEED(64), .INITIAL_Y_SPEED(0), .Y_ACCEL(0)) dut_a (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .launch(launch), .park(park),
        .collision(collision), .HitEdgeCode(code), .topLeftX(ax), .topLeftY(ay), .moving(am)
    );

    smiley_move_ctrl dut_b (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .launch(launch_b), .park(park),
        .collision(1'b0), .HitEdgeCode(4'b0000), .topLeftX(bx), .topLeftY(by), .moving(bm)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic frame;
        sof = 1'b1;
        tick;
        sof = 1'b0;
        repeat (3) tick;
    endtask

    task automatic hit(input logic [3:0] c, input int n);
        collision = 1'b1;
        code = c;
        repeat (n) tick;
        collision = 1'b0;
        code = 4'b0;
    endtask

    initial begin
        repeat (2) tick;
        check("rst_ax", ax, 280);
        check("rst_ay", ay, 185);
        check("rst_am", am, 0);
        check("rst_bx", bx, 280);
        check("rst_by", by, 185);
        check("rst_bm", bm, 0);
        resetN = 1'b1;
        tick;
        repeat (3) frame;
        check("idle_ax", ax, 280);
        check("idle_ay", ay, 185);
        check("idle_am", am, 0);

        launch = 1'b1;
        tick;
        launch = 1'b0;
        check("launch_am", am, 1);
        sof = 1'b1;
        tick;
        sof = 1'b0;
        tick;
        tick;
        check("f1_ax_edge2", ax, 280);
        tick;
        check("f1_ax_edge3", ax, 281);
        check("f1_ay", ay, 185);
        frame;
        check("f2_ax", ax, 282);
        frame;
        check("f3_ax", ax, 283);
        check("f3_ay", ay, 185);

        hit(4'b0010, 5);
        check("midframe_ax", ax, 283);
        frame;
        check("bounce_r_ax", ax, 282);
        frame;
        check("after_bounce_ax", ax, 281);
        hit(4'b0010, 5);
        frame;
        check("no_reverse_ax", ax, 280);

        sof = 1'b1;
        collision = 1'b1;
        code = 4'b1000;
        tick;
        sof = 1'b0;
        collision = 1'b0;
        code = 4'b0;
        repeat (3) tick;
        check("sof_hit_ax", ax, 281);

        sof = 1'b1;
        tick;
        sof = 1'b0;
        collision = 1'b1;
        code = 4'b0010;
        tick;
        collision = 1'b0;
        code = 4'b0;
        tick;
        tick;
        check("upd_hit_late_ax", ax, 282);
        frame;
        check("upd_hit_next_ax", ax, 281);

        launch_b = 1'b1;
        tick;
        launch_b = 1'b0;
        check("b_launch_bm", bm, 1);
        px = 280 * 64;
        py = 185 * 64;
        sx = 40;
        sy = 20;
        for (int f = 0; f < 500; f++) begin
            frame;
            sy = (sy < 230) ? sy + 1 : sy;
            px = (px + sx > 36864) ? 36864 : px + sx;
            py = (py + sy > 28672) ? 28672 : py + sy;
            check("b_x", bx, px / 64);
            check("b_y", by, py / 64);
            check("b_yspeed", int'(dut_b.spd_y_q), sy);
        end
        check("b_x_clamp", bx, 576);
        check("b_y_clamp", by, 448);
        check("b_yspeed_sat", int'(dut_b.spd_y_q), 230);

        check("a_x_floor", ax, 0);
        sof = 1'b1;
        tick;
        sof = 1'b0;
        tick;
        check("a_in_position", int'(dut_a.state_q), int'(S_POSITION));
        resetN = 1'b0;
        #1;
        check("arst_ax", ax, 280);
        check("arst_ay", ay, 185);
        check("arst_am", am, 0);
        check("arst_state", int'(dut_a.state_q), int'(S_IDLE));
        check("arst_bx", bx, 280);
        tick;
        resetN = 1'b1;
        frame;
        check("post_rst_ax", ax, 280);
        check("post_rst_am", am, 0);

        launch = 1'b1;
        tick;
        launch = 1'b0;
        frame;
        check("relaunch_ax", ax, 281);
        park = 1'b1;
        frame;
        park = 1'b0;
        check("park_am", am, 0);
        check("park_ax", ax, 280);
        check("park_ay", ay, 185);
        frame;
        check("parked_ax", ax, 280);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
